// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port RAM with a
// registered read port.
//
// Ports
//   CLK, RST_n             clock, asynchronous active-low reset
//   req0/addr0             port 0 (fetch) read request
//   gnt0/rvalid0/rdata0    port 0 grant and read response
//   req1/we1/addr1/wdata1  port 1 (load/store) request
//   gnt1/rvalid1/rdata1    port 1 grant and read response
//   daddr/MemRead/MemWrite/ddata_w  RAM command, driven in the grant cycle
//   ddata_r                RAM read data, valid one cycle after MemRead
//
// Port 1 wins ties unless port 0 has waited MAX_WAIT cycles or more.
// Grants are combinational, so one access can be issued every cycle.
//
// state | meaning
// IDLE  | no read issued last cycle, no response due
// RESP  | a read was issued last cycle; tag_q names the port that gets ddata_r
module ram_arbiter #(
    parameter int data_width = 32,
    parameter int addr_width = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  req0,
    input  logic [addr_width-1:0] addr0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [data_width-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [addr_width-1:0] addr1,
    input  logic [data_width-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [data_width-1:0] rdata1,
    output logic [addr_width-1:0] daddr,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic [data_width-1:0] ddata_w,
    input  logic [data_width-1:0] ddata_r
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] tag_q, tag_d;      // {read0, read1} of the previous cycle
    logic [3:0] wait0_q, wait0_d;
    logic       starve;

    assign starve = (wait0_q >= 4'(MAX_WAIT));

    // Grant and RAM command. Gating with RST_n keeps the RAM quiet while
    // reset is held, independent of the clock.
    always_comb begin
        gnt0     = RST_n & req0 & (~req1 | starve);
        gnt1     = RST_n & req1 & ~gnt0;
        daddr    = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ddata_w  = '0;
        if (gnt0) begin
            daddr   = addr0;
            MemRead = 1'b1;
        end else if (gnt1) begin
            daddr = addr1;
            if (we1) begin
                MemWrite = 1'b1;
                ddata_w  = wdata1;
            end else begin
                MemRead = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            tag_q   <= 2'b00;
            wait0_q <= 4'd0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            wait0_q <= wait0_d;
        end
    end

    always_comb begin
        tag_d   = {gnt0, gnt1 & ~we1};
        state_d = (tag_d != 2'b00) ? RESP : IDLE;
        wait0_d = 4'd0;
        if (req0 && !gnt0) begin
            // saturate rather than wrap so a long stall can never look fresh
            wait0_d = (wait0_q == 4'hF) ? wait0_q : wait0_q + 4'd1;
        end
    end

    always_comb begin
        rvalid0 = (state_q == RESP) & tag_q[1];
        rvalid1 = (state_q == RESP) & tag_q[0];
        rdata0  = rvalid0 ? ddata_r : '0;
        rdata1  = rvalid1 ? ddata_r : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MW = 4;

    logic          clk, rst_n;
    logic          req0, gnt0, rvalid0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] rdata0;
    logic          req1, we1, gnt1, rvalid1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1, rdata1;
    logic [AW-1:0] daddr;
    logic          MemWrite, MemRead;
    logic [DW-1:0] ddata_w, ddata_r;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.data_width(DW), .addr_width(AW), .MAX_WAIT(MW)) dut (
        .CLK(clk), .RST_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .daddr(daddr), .MemWrite(MemWrite), .MemRead(MemRead),
        .ddata_w(ddata_w), .ddata_r(ddata_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // environment RAM, driven purely by the DUT's command outputs
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (MemWrite) ram[daddr] <= ddata_w;
        if (MemRead)  ddata_r <= ram[daddr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: its own copy of memory, a wait count and the one
    // response that is due this cycle.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            mwait;
    bit            mg0, mg1;
    bit            exp_rv0, exp_rv1;
    logic [DW-1:0] exp_data;

    always @(negedge clk) begin
        bit            e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        if (!rst_n) begin
            mwait = 0; mg0 = 0; mg1 = 0; exp_rv0 = 0; exp_rv1 = 0;
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_rd", MemRead, 0);
            chk("rst_wr", MemWrite, 0);
            chk("rst_rv0", rvalid0, 0);
            chk("rst_rv1", rvalid1, 0);
        end else begin
            mg0    = req0 && (!req1 || mwait >= MW);
            mg1    = req1 && !mg0;
            e_addr = mg0 ? addr0 : (mg1 ? addr1 : '0);
            e_rd   = mg0 || (mg1 && !we1);
            e_wr   = mg1 && we1;
            e_wd   = e_wr ? wdata1 : '0;
            chk("gnt0", gnt0, mg0);
            chk("gnt1", gnt1, mg1);
            chk("both_gnt", gnt0 & gnt1, 0);
            chk("daddr", daddr, e_addr);
            chk("MemRead", MemRead, e_rd);
            chk("MemWrite", MemWrite, e_wr);
            chk("ddata_w", ddata_w, e_wd);
            chk("rvalid0", rvalid0, exp_rv0);
            chk("rvalid1", rvalid1, exp_rv1);
            chk("rdata0", rdata0, exp_rv0 ? exp_data : '0);
            chk("rdata1", rdata1, exp_rv1 ? exp_data : '0);
            exp_rv0 = mg0;
            exp_rv1 = mg1 && !we1;
            if (e_rd) exp_data = ref_mem[e_addr];
            if (e_wr) ref_mem[e_addr] = wdata1;
            mwait = (req0 && !mg0) ? mwait + 1 : 0;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic drive(input bit r0, input int a0, input bit r1, input bit w, input int a1,
                         input logic [DW-1:0] wd);
        req0 = r0; addr0 = AW'(a0); req1 = r1; we1 = w; addr1 = AW'(a1); wdata1 = wd;
    endtask

    initial begin
        logic [DW-1:0] v;
        rst_n = 1'b0;
        drive(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
            ram[i] = v;
            ref_mem[i] = v;
        end
        ram[5] = 32'h0000_A5A5;
        ref_mem[5] = 32'h0000_A5A5;

        // reset held with requests present: everything must stay quiet
        #12;
        chk("rst_lit_gnt0", gnt0, 0);
        chk("rst_lit_gnt1", gnt1, 0);
        chk("rst_lit_memrd", MemRead, 0);
        repeat (2) step();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // single fetch from address 5
        step(); drive(1, 5, 0, 0, 0, 0);
        sample();
        chk("fetch_gnt0", gnt0, 1);
        chk("fetch_daddr", daddr, 5);
        step(); drive(0, 0, 0, 0, 0, 0);
        sample();
        chk("fetch_rv0", rvalid0, 1);
        chk("fetch_rdata0", rdata0, 32'h0000_A5A5);
        chk("fetch_rv1", rvalid1, 0);

        // write then read the same address on port 1
        step(); drive(0, 0, 1, 1, 7, 32'h1234);
        sample();
        chk("wr_memwrite", MemWrite, 1);
        chk("wr_ddata_w", ddata_w, 32'h1234);
        step(); drive(0, 0, 1, 0, 7, 0);
        sample();
        chk("rd_memread", MemRead, 1);
        step(); drive(0, 0, 0, 0, 0, 0);
        sample();
        chk("wr_rd_rv1", rvalid1, 1);
        chk("wr_rd_rdata1", rdata1, 32'h1234);

        // both ports held: four port-1 grants, then one port-0 grant
        step(); drive(1, 3, 1, 0, 4, 0);
        for (int i = 0; i < 15; i++) begin
            sample();
            chk("starve_gnt0", gnt0, (i % 5) == 4);
            chk("starve_gnt1", gnt1, (i % 5) != 4);
            step();
        end

        // alternating single-port reads
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1, 1, 0, 0, 0, 0);
            else            drive(0, 0, 1, 0, 2, 0);
            step();
        end

        // idle bus
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("idle_daddr", daddr, 0);
            chk("idle_memrd", MemRead | MemWrite, 0);
            step();
        end

        // reset mid-cycle right after a port-0 read grant
        drive(1, 3, 0, 0, 0, 0);
        sample();
        chk("pre_rst_gnt0", gnt0, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rv0", rvalid0, 0);
        chk("async_rdata0", rdata0, 0);
        chk("async_gnt0", gnt0, 0);
        chk("async_memrd", MemRead, 0);
        chk("async_wait0", dut.wait0_q, 0);
        repeat (2) step();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        sample();
        chk("post_rst_rv0", rvalid0, 0);

        // first request right after release is granted at once
        step(); rst_n = 1'b0;
        step(); drive(1, 9, 0, 0, 0, 0); rst_n = 1'b1;
        sample();
        chk("first_gnt0", gnt0, 1);

        // random traffic; requesters hold until granted
        for (int n = 0; n < 2000; n++) begin
            step();
            if (!req0 || mg0) begin
                req0  = ($urandom_range(0, 3) != 0);
                addr0 = AW'($urandom_range(0, 15));
            end
            if (!req1 || mg1) begin
                req1   = ($urandom_range(0, 2) != 0);
                we1    = $urandom_range(0, 1) == 1;
                addr1  = AW'($urandom_range(0, 15));
                wdata1 = $urandom;
            end
        end
        step(); drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
